// File: rtl/vproc_result_rx.sv
// Core-side receiver for the coprocessor result channel: tracks outstanding IDs, accepts
// results through a single-entry stage and drives GPR writeback, exceptions and retirement.
module vproc_result_rx #(
    parameter int unsigned XIF_ID_W       = 3,
    parameter bit          DONT_CARE_ZERO = 1'b0,
    localparam int unsigned XIF_ID_CNT    = 1 << XIF_ID_W
) (
    input  logic                  clk_i,
    input  logic                  async_rst_ni,
    input  logic                  sync_rst_ni,

    input  logic                  offload_valid_i,
    input  logic [XIF_ID_W-1:0]   offload_id_i,
    input  logic                  offload_we_i,
    input  logic [4:0]            offload_rd_i,

    input  logic                  result_valid_i,
    output logic                  result_ready_o,
    input  logic [XIF_ID_W-1:0]   result_id_i,
    input  logic [31:0]           result_data_i,
    input  logic [4:0]            result_rd_i,
    input  logic                  result_we_i,
    input  logic                  result_exc_i,
    input  logic [5:0]            result_exccode_i,

    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [4:0]            wb_addr_o,
    output logic [31:0]           wb_data_o,

    output logic                  exc_valid_o,
    output logic [XIF_ID_W-1:0]   exc_id_o,
    output logic [5:0]            exc_code_o,

    output logic                  retire_valid_o,
    output logic [XIF_ID_W-1:0]   retire_id_o,

    output logic [XIF_ID_CNT-1:0] outstanding_o,
    output logic                  protocol_err_o
);

    localparam logic DC = DONT_CARE_ZERO ? 1'b0 : 1'bx;

    logic [XIF_ID_CNT-1:0] r_pending;
    logic [XIF_ID_CNT-1:0] w_pending_d;
    logic                  r_tbl_we [XIF_ID_CNT];
    logic [4:0]            r_tbl_rd [XIF_ID_CNT];

    logic                  r_stage_valid;
    logic [XIF_ID_W-1:0]   r_stage_id;
    logic [31:0]           r_stage_data;
    logic [4:0]            r_stage_rd;
    logic                  r_stage_we;
    logic                  r_stage_exc;
    logic [5:0]            r_stage_exccode;
    logic                  r_protocol_err;

    logic w_complete;
    logic w_accept;
    logic w_hit;
    logic w_load;
    logic w_err_mismatch;
    logic w_err_offload;
    logic w_err;

    // An exception suppresses the writeback, so the stage drains without wb_ready_i.
    assign w_complete     = r_stage_valid & (r_stage_exc | ~r_stage_we | wb_ready_i);
    assign result_ready_o = ~r_stage_valid | w_complete;
    assign w_accept       = result_valid_i & result_ready_o;
    assign w_hit          = r_pending[result_id_i];
    assign w_load         = w_accept & w_hit;

    assign w_err_mismatch = w_load & ~result_exc_i &
                            ((result_we_i != r_tbl_we[result_id_i]) |
                             (r_tbl_we[result_id_i] & (result_rd_i != r_tbl_rd[result_id_i])));
    // Reusing an ID in the very cycle it retires is legal.
    assign w_err_offload  = offload_valid_i & r_pending[offload_id_i] &
                            ~(w_complete & (r_stage_id == offload_id_i));
    assign w_err          = (w_accept & ~w_hit) | w_err_mismatch | w_err_offload;

    always_comb begin
        w_pending_d = r_pending;
        if (w_complete) begin
            w_pending_d[r_stage_id] = 1'b0;
        end
        if (offload_valid_i) begin
            w_pending_d[offload_id_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_pending      <= '0;
            r_stage_valid  <= 1'b0;
            r_protocol_err <= 1'b0;
        end else if (!sync_rst_ni) begin
            r_pending      <= '0;
            r_stage_valid  <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_pending      <= w_pending_d;
            r_protocol_err <= r_protocol_err | w_err;
            if (result_ready_o) begin
                r_stage_valid <= w_load;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (offload_valid_i) begin
            r_tbl_we[offload_id_i] <= offload_we_i;
            r_tbl_rd[offload_id_i] <= offload_rd_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_load) begin
            r_stage_id      <= result_id_i;
            r_stage_data    <= result_data_i;
            r_stage_rd      <= r_tbl_rd[result_id_i];
            r_stage_we      <= r_tbl_we[result_id_i];
            r_stage_exc     <= result_exc_i;
            r_stage_exccode <= result_exccode_i;
        end
    end

    always_comb begin
        wb_valid_o     = r_stage_valid & r_stage_we & ~r_stage_exc;
        wb_addr_o      = {5{DC}};
        wb_data_o      = {32{DC}};
        exc_valid_o    = r_stage_valid & r_stage_exc;
        exc_id_o       = {XIF_ID_W{DC}};
        exc_code_o     = {6{DC}};
        retire_valid_o = w_complete;
        retire_id_o    = {XIF_ID_W{DC}};
        if (wb_valid_o) begin
            wb_addr_o = r_stage_rd;
            wb_data_o = r_stage_data;
        end
        if (exc_valid_o) begin
            exc_id_o   = r_stage_id;
            exc_code_o = r_stage_exccode;
        end
        if (w_complete) begin
            retire_id_o = r_stage_id;
        end
    end

    assign outstanding_o  = r_pending;
    assign protocol_err_o = r_protocol_err;

endmodule

// File: tb/tb_vproc_result_rx.sv
// Directed-vector bench for vproc_result_rx: a table of per-cycle stimulus and expected
// outputs, plus hand-written stall and mid-writeback reset sequences.
module tb_vproc_result_rx;

    typedef struct packed {
        logic        srst_n;
        logic        off_v;
        logic [2:0]  off_id;
        logic        off_we;
        logic [4:0]  off_rd;
        logic        res_v;
        logic [2:0]  res_id;
        logic [31:0] res_data;
        logic [4:0]  res_rd;
        logic        res_we;
        logic        res_exc;
        logic [5:0]  res_code;
        logic        wbr;
    } in_t;

    typedef struct packed {
        logic        rdy;
        logic        wb_v;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        exc_v;
        logic [2:0]  exc_id;
        logic [5:0]  exc_code;
        logic        ret_v;
        logic [2:0]  ret_id;
        logic [7:0]  outst;
        logic        perr;
    } exp_t;

    typedef struct {
        in_t   i;
        exp_t  e;
        string name;
    } vec_t;

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        sync_rst_n;
    logic        offload_valid;
    logic [2:0]  offload_id;
    logic        offload_we;
    logic [4:0]  offload_rd;
    logic        result_valid;
    logic        result_ready;
    logic [2:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        result_we;
    logic        result_exc;
    logic [5:0]  result_exccode;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [2:0]  exc_id;
    logic [5:0]  exc_code;
    logic        retire_valid;
    logic [2:0]  retire_id;
    logic [7:0]  outstanding;
    logic        protocol_err;

    int n_vec  = 0;
    int n_miss = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    vproc_result_rx #(
        .XIF_ID_W       (3),
        .DONT_CARE_ZERO (1'b1)
    ) dut (
        .clk_i            (clk),
        .async_rst_ni     (async_rst_n),
        .sync_rst_ni      (sync_rst_n),
        .offload_valid_i  (offload_valid),
        .offload_id_i     (offload_id),
        .offload_we_i     (offload_we),
        .offload_rd_i     (offload_rd),
        .result_valid_i   (result_valid),
        .result_ready_o   (result_ready),
        .result_id_i      (result_id),
        .result_data_i    (result_data),
        .result_rd_i      (result_rd),
        .result_we_i      (result_we),
        .result_exc_i     (result_exc),
        .result_exccode_i (result_exccode),
        .wb_valid_o       (wb_valid),
        .wb_ready_i       (wb_ready),
        .wb_addr_o        (wb_addr),
        .wb_data_o        (wb_data),
        .exc_valid_o      (exc_valid),
        .exc_id_o         (exc_id),
        .exc_code_o       (exc_code),
        .retire_valid_o   (retire_valid),
        .retire_id_o      (retire_id),
        .outstanding_o    (outstanding),
        .protocol_err_o   (protocol_err)
    );

    function automatic in_t mk(input logic srst, input logic ov, input logic [2:0] oid,
                               input logic owe, input logic [4:0] ord, input logic rv,
                               input logic [2:0] rid, input logic [31:0] rdata,
                               input logic [4:0] rrd, input logic rwe, input logic rexc,
                               input logic [5:0] rcode, input logic wbr);
        in_t v;
        v = '{srst, ov, oid, owe, ord, rv, rid, rdata, rrd, rwe, rexc, rcode, wbr};
        return v;
    endfunction

    function automatic in_t idle(input logic wbr);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wbr);
    endfunction

    function automatic exp_t ex(input logic rdy, input logic wbv, input logic [4:0] waddr,
                                input logic [31:0] wdata, input logic excv,
                                input logic [2:0] eid, input logic [5:0] ecode,
                                input logic retv, input logic [2:0] rid,
                                input logic [7:0] outst, input logic perr);
        exp_t e;
        e = '{rdy, wbv, waddr, wdata, excv, eid, ecode, retv, rid, outst, perr};
        return e;
    endfunction

    function automatic exp_t quiet(input logic [7:0] outst, input logic perr);
        return ex(1, 0, 0, 0, 0, 0, 0, 0, 0, outst, perr);
    endfunction

    task automatic add(input in_t vi, input exp_t ve, input string nm);
        vec_t v;
        v.i = vi;
        v.e = ve;
        v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic apply(input in_t vi, input exp_t ve, input string nm);
        exp_t act;
        @(negedge clk);
        sync_rst_n     = vi.srst_n;
        offload_valid  = vi.off_v;
        offload_id     = vi.off_id;
        offload_we     = vi.off_we;
        offload_rd     = vi.off_rd;
        result_valid   = vi.res_v;
        result_id      = vi.res_id;
        result_data    = vi.res_data;
        result_rd      = vi.res_rd;
        result_we      = vi.res_we;
        result_exc     = vi.res_exc;
        result_exccode = vi.res_code;
        wb_ready       = vi.wbr;
        #1;
        act = '{result_ready, wb_valid, wb_addr, wb_data, exc_valid, exc_id, exc_code,
                retire_valid, retire_id, outstanding, protocol_err};
        n_vec++;
        if (act !== ve) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", nm, act, ve);
        end
    endtask

    initial begin
        async_rst_n = 1'b0;
        sync_rst_n  = 1'b1;
        offload_valid = 0; offload_id = 0; offload_we = 0; offload_rd = 0;
        result_valid = 0; result_id = 0; result_data = 0; result_rd = 0;
        result_we = 0; result_exc = 0; result_exccode = 0; wb_ready = 1;
        repeat (2) @(negedge clk);
        async_rst_n = 1'b1;

        add(idle(1), quiet(8'h00, 0), "reset");
        add(mk(1, 1, 2, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1), quiet(8'h00, 0), "off2");
        add(mk(1, 0, 0, 0, 0, 1, 2, 32'hDEADBEEF, 5, 1, 0, 0, 1), quiet(8'h04, 0), "res2");
        add(idle(1), ex(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 2, 8'h04, 0), "wb2");
        add(idle(1), quiet(8'h00, 0), "done2");
        add(mk(1, 1, 4, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1), quiet(8'h00, 0), "off4");
        add(mk(1, 0, 0, 0, 0, 1, 4, 32'h1234, 7, 1, 1, 13, 0), quiet(8'h10, 0), "res4exc");
        add(idle(0), ex(1, 0, 0, 0, 1, 4, 13, 1, 4, 8'h10, 0), "exc4");
        add(idle(1), quiet(8'h00, 0), "done4");
        add(mk(1, 0, 0, 0, 0, 1, 6, 32'h66, 6, 1, 0, 0, 1), quiet(8'h00, 0), "res6");
        add(idle(1), quiet(8'h00, 1), "drop6");
        add(idle(1), quiet(8'h00, 1), "sticky");
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), quiet(8'h00, 1), "srst");
        add(idle(1), quiet(8'h00, 0), "post_srst");
        add(mk(1, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1), quiet(8'h00, 0), "off1");
        add(mk(1, 0, 0, 0, 0, 1, 1, 32'hA5A5A5A5, 9, 1, 0, 0, 1), quiet(8'h02, 0), "res1rd9");
        add(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
            ex(1, 1, 3, 32'hA5A5A5A5, 0, 0, 0, 1, 1, 8'h02, 1), "wb1_reoff");
        add(idle(1), quiet(8'h02, 1), "hold1");
        add(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1), quiet(8'h02, 1), "res1we0");
        add(idle(1), ex(1, 0, 0, 0, 0, 0, 0, 1, 1, 8'h02, 1), "ret1_nowb");
        add(idle(1), quiet(8'h00, 1), "clr1");

        foreach (tbl[k]) apply(tbl[k].i, tbl[k].e, tbl[k].name);

        // Streaming ids 0..7 with a three-cycle writeback stall.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), quiet(8'h00, 1), "s_srst");
        apply(mk(1, 1, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 1), quiet(8'h00, 0), "s0");
        apply(mk(1, 1, 1, 1, 9, 1, 0, 32'h100, 8, 1, 0, 0, 1), quiet(8'h01, 0), "s1");
        apply(mk(1, 1, 2, 1, 10, 1, 1, 32'h101, 9, 1, 0, 0, 1),
              ex(1, 1, 8, 32'h100, 0, 0, 0, 1, 0, 8'h03, 0), "s2");
        apply(mk(1, 1, 3, 1, 11, 1, 2, 32'h102, 10, 1, 0, 0, 0),
              ex(0, 1, 9, 32'h101, 0, 0, 0, 0, 0, 8'h06, 0), "stall0");
        apply(mk(1, 1, 4, 1, 12, 1, 2, 32'h102, 10, 1, 0, 0, 0),
              ex(0, 1, 9, 32'h101, 0, 0, 0, 0, 0, 8'h0E, 0), "stall1");
        apply(mk(1, 1, 5, 1, 13, 1, 2, 32'h102, 10, 1, 0, 0, 0),
              ex(0, 1, 9, 32'h101, 0, 0, 0, 0, 0, 8'h1E, 0), "stall2");
        apply(mk(1, 1, 6, 1, 14, 1, 2, 32'h102, 10, 1, 0, 0, 1),
              ex(1, 1, 9, 32'h101, 0, 0, 0, 1, 1, 8'h3E, 0), "s6");
        apply(mk(1, 1, 7, 1, 15, 1, 3, 32'h103, 11, 1, 0, 0, 1),
              ex(1, 1, 10, 32'h102, 0, 0, 0, 1, 2, 8'h7C, 0), "s7");
        apply(mk(1, 0, 0, 0, 0, 1, 4, 32'h104, 12, 1, 0, 0, 1),
              ex(1, 1, 11, 32'h103, 0, 0, 0, 1, 3, 8'hF8, 0), "s8");
        apply(mk(1, 0, 0, 0, 0, 1, 5, 32'h105, 13, 1, 0, 0, 1),
              ex(1, 1, 12, 32'h104, 0, 0, 0, 1, 4, 8'hF0, 0), "s9");
        apply(mk(1, 0, 0, 0, 0, 1, 6, 32'h106, 14, 1, 0, 0, 1),
              ex(1, 1, 13, 32'h105, 0, 0, 0, 1, 5, 8'hE0, 0), "s10");
        apply(mk(1, 0, 0, 0, 0, 1, 7, 32'h107, 15, 1, 0, 0, 1),
              ex(1, 1, 14, 32'h106, 0, 0, 0, 1, 6, 8'hC0, 0), "s11");
        apply(idle(1), ex(1, 1, 15, 32'h107, 0, 0, 0, 1, 7, 8'h80, 0), "s12");
        apply(idle(1), quiet(8'h00, 0), "s13");

        // Synchronous reset while a write waits on wb_ready_i.
        apply(mk(1, 1, 5, 1, 20, 0, 0, 0, 0, 0, 0, 0, 1), quiet(8'h00, 0), "r_off5");
        apply(mk(1, 0, 0, 0, 0, 1, 5, 32'hCAFEF00D, 20, 1, 0, 0, 0), quiet(8'h20, 0), "r_res5");
        apply(idle(0), ex(0, 1, 20, 32'hCAFEF00D, 0, 0, 0, 0, 0, 8'h20, 0), "r_wait");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              ex(0, 1, 20, 32'hCAFEF00D, 0, 0, 0, 0, 0, 8'h20, 0), "r_srst");
        apply(idle(1), quiet(8'h00, 0), "r_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
